// File: rtl/vtm_chk.sv
// Native video timing checker: measures href width, inter-line blank and lines/frame; 1-cycle flag/measure latency, passive monitor (no backpressure).
// Blank measurement and err_hblk are built only when VTM_CHK_HBLK_EN is defined.
module vtm_chk #(
    parameter int EXP_HWIN = 640,
    parameter int EXP_HBLK = 160,
    parameter int EXP_VWIN = 480,
    parameter int CNTW     = 12
) (
    input  logic            pclk,
    input  logic            prst,
    input  logic            i_chk_en,
    input  logic            i_fstr,
    input  logic            i_fend,
    input  logic            i_vref,
    input  logic            i_href,
    input  logic            i_err_clr,
    output logic [CNTW-1:0] o_hwin,
    output logic [CNTW-1:0] o_hblk,
    output logic [CNTW-1:0] o_vwin,
    output logic            o_meas_vld,
    output logic [7:0]      o_fm_cnt,
    output logic            o_err_hwin,
    output logic            o_err_hblk,
    output logic            o_err_vwin,
    output logic            o_err_seq
);
    localparam logic [CNTW-1:0] HWIN_X = CNTW'(EXP_HWIN);
    localparam logic [CNTW-1:0] VWIN_X = CNTW'(EXP_VWIN);

    if ((2 ** CNTW) <= EXP_HWIN || (2 ** CNTW) <= EXP_HBLK || (2 ** CNTW) <= EXP_VWIN) begin : g_cntw_chk
        $error("vtm_chk: CNTW too narrow for expected lengths");
    end

    typedef enum logic {IDLE = 1'b0, FRAME = 1'b1} state_t;

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (&v) ? v : v + CNTW'(1);
    endfunction

    // A saturated count can never be trusted as a match.
    function automatic logic bad_len(input logic [CNTW-1:0] v, input logic [CNTW-1:0] x);
        return (v != x) || (&v);
    endfunction

    state_t          state_q, state_d;
    logic            href_q;
    logic [CNTW-1:0] run_cnt_q, run_cnt_d, line_len_q, line_len_d, line_cnt_q, line_cnt_d;
    logic [CNTW-1:0] hwin_q, hwin_d, vwin_q, vwin_d;
    logic [7:0]      fm_q, fm_d;
    logic            meas_q, meas_d;
    logic            err_hwin_q, err_hwin_d, err_vwin_q, err_vwin_d, err_seq_q, err_seq_d;
    logic            rise, fall, in_frame, frame_done, clr_lines, seq_err, hwin_bad, vwin_bad;

    assign rise     = i_href & ~href_q;
    assign fall     = ~i_href & href_q;
    assign in_frame = i_chk_en && (state_q == FRAME);

    always_comb begin
        state_d    = state_q;
        frame_done = 1'b0;
        clr_lines  = 1'b0;
        seq_err    = 1'b0;
        if (!i_chk_en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_fstr) begin
                        state_d   = FRAME;
                        clr_lines = 1'b1;
                    end
                    if (i_fend || i_href) seq_err = 1'b1;
                end
                FRAME: begin
                    // fend takes priority; a simultaneous fstr is only flagged
                    if (i_fend) begin
                        state_d    = IDLE;
                        frame_done = 1'b1;
                    end else if (i_fstr) begin
                        clr_lines = 1'b1;
                    end
                    if (i_fstr || (i_href && !i_vref)) seq_err = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        run_cnt_d  = run_cnt_q;
        line_len_d = line_len_q;
        line_cnt_d = line_cnt_q;
        hwin_d     = hwin_q;
        vwin_d     = vwin_q;
        fm_d       = fm_q;
        meas_d     = 1'b0;
        hwin_bad   = 1'b0;
        vwin_bad   = 1'b0;
        if (in_frame) begin
            if (i_href) run_cnt_d = rise ? CNTW'(1) : sat_inc(run_cnt_q);
            if (fall) begin
                line_len_d = run_cnt_q;
                hwin_bad   = bad_len(run_cnt_q, HWIN_X);
            end
            if (rise) line_cnt_d = sat_inc(line_cnt_q);
        end
        if (clr_lines) line_cnt_d = '0;
        if (frame_done) begin
            hwin_d   = line_len_q;
            vwin_d   = line_cnt_q;
            vwin_bad = bad_len(line_cnt_q, VWIN_X);
            fm_d     = fm_q + 8'd1;
            meas_d   = 1'b1;
        end
        if (!i_chk_en) fm_d = '0;
        err_hwin_d = (err_hwin_q & ~i_err_clr) | hwin_bad;
        err_vwin_d = (err_vwin_q & ~i_err_clr) | vwin_bad;
        err_seq_d  = (err_seq_q & ~i_err_clr) | seq_err;
    end

    always_ff @(posedge pclk) begin
        if (prst) begin
            state_q    <= IDLE;
            href_q     <= 1'b0;
            run_cnt_q  <= '0;
            line_len_q <= '0;
            line_cnt_q <= '0;
            hwin_q     <= '0;
            vwin_q     <= '0;
            fm_q       <= '0;
            meas_q     <= 1'b0;
            err_hwin_q <= 1'b0;
            err_vwin_q <= 1'b0;
            err_seq_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            href_q     <= i_href;
            run_cnt_q  <= run_cnt_d;
            line_len_q <= line_len_d;
            line_cnt_q <= line_cnt_d;
            hwin_q     <= hwin_d;
            vwin_q     <= vwin_d;
            fm_q       <= fm_d;
            meas_q     <= meas_d;
            err_hwin_q <= err_hwin_d;
            err_vwin_q <= err_vwin_d;
            err_seq_q  <= err_seq_d;
        end
    end

`ifdef VTM_CHK_HBLK_EN
    localparam logic [CNTW-1:0] HBLK_X = CNTW'(EXP_HBLK);
    logic [CNTW-1:0] blk_cnt_q, blk_cnt_d, blk_len_q, blk_len_d, hblk_q, hblk_d;
    logic            err_hblk_q, err_hblk_d, hblk_bad;

    // Blanks are only timed between lines: vref low or no line yet stops the count.
    always_comb begin
        blk_cnt_d = blk_cnt_q;
        blk_len_d = blk_len_q;
        hblk_d    = hblk_q;
        hblk_bad  = 1'b0;
        if (in_frame && i_vref && (line_cnt_q != '0)) begin
            if (!i_href) blk_cnt_d = fall ? CNTW'(1) : sat_inc(blk_cnt_q);
            if (rise) begin
                blk_len_d = blk_cnt_q;
                hblk_bad  = bad_len(blk_cnt_q, HBLK_X);
            end
        end
        if (frame_done) hblk_d = blk_len_q;
        err_hblk_d = (err_hblk_q & ~i_err_clr) | hblk_bad;
    end

    always_ff @(posedge pclk) begin
        if (prst) begin
            blk_cnt_q  <= '0;
            blk_len_q  <= '0;
            hblk_q     <= '0;
            err_hblk_q <= 1'b0;
        end else begin
            blk_cnt_q  <= blk_cnt_d;
            blk_len_q  <= blk_len_d;
            hblk_q     <= hblk_d;
            err_hblk_q <= err_hblk_d;
        end
    end

    assign o_hblk     = hblk_q;
    assign o_err_hblk = err_hblk_q;
`else
    assign o_hblk     = '0;
    assign o_err_hblk = 1'b0;
`endif

    assign o_hwin     = hwin_q;
    assign o_vwin     = vwin_q;
    assign o_meas_vld = meas_q;
    assign o_fm_cnt   = fm_q;
    assign o_err_hwin = err_hwin_q;
    assign o_err_vwin = err_vwin_q;
    assign o_err_seq  = err_seq_q;
endmodule

// File: tb/tb_vtm_chk.sv
// Self-checking bench for vtm_chk using a scaled-down raster (16x10, blank 6, 6-bit counters).
module tb_vtm_chk;
    localparam int HW = 16, HB = 6, VW = 10, CW = 6;
`ifdef VTM_CHK_HBLK_EN
    localparam int   HBX     = HB;
    localparam logic HBLK_ON = 1'b1;
`else
    localparam int   HBX     = 0;
    localparam logic HBLK_ON = 1'b0;
`endif

    logic          pclk, prst, en, fstr, fend, vref, href, clr;
    logic [CW-1:0] o_hwin, o_hblk, o_vwin;
    logic          o_meas_vld;
    logic [7:0]    o_fm_cnt;
    logic          o_err_hwin, o_err_hblk, o_err_vwin, o_err_seq;

    typedef struct packed {
        logic [CW-1:0] hwin;
        logic [CW-1:0] hblk;
        logic [CW-1:0] vwin;
        logic [7:0]    fm;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   fm_exp, n_cmp, n_bad;

    vtm_chk #(.EXP_HWIN(HW), .EXP_HBLK(HB), .EXP_VWIN(VW), .CNTW(CW)) dut (
        .pclk(pclk), .prst(prst), .i_chk_en(en), .i_fstr(fstr), .i_fend(fend),
        .i_vref(vref), .i_href(href), .i_err_clr(clr),
        .o_hwin(o_hwin), .o_hblk(o_hblk), .o_vwin(o_vwin), .o_meas_vld(o_meas_vld),
        .o_fm_cnt(o_fm_cnt), .o_err_hwin(o_err_hwin), .o_err_hblk(o_err_hblk),
        .o_err_vwin(o_err_vwin), .o_err_seq(o_err_seq)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic cyc;
        @(negedge pclk);
    endtask

    task automatic send_line(input int hw, input int bl);
        href = 1'b1;
        repeat (hw) cyc();
        href = 1'b0;
        repeat (bl) cyc();
    endtask

    task automatic lines(input int n);
        repeat (n) send_line(HW, HB);
    endtask

    task automatic frame_open;
        fstr = 1'b1;
        cyc();
        fstr = 1'b0;
        vref = 1'b1;
        cyc();
    endtask

    task automatic frame_close;
        vref = 1'b0;
        cyc();
        fend = 1'b1;
        cyc();
        fend = 1'b0;
    endtask

    task automatic push_exp(input int hw, input int hb, input int vw);
        fm_exp = (fm_exp + 1) % 256;
        sb.push_back({CW'(hw), CW'(hb), CW'(vw), 8'(fm_exp)});
    endtask

    task automatic err_clear;
        clr = 1'b1;
        cyc();
        clr = 1'b0;
    endtask

    task automatic test_reset;
        prst = 1'b1;
        repeat (2) cyc();
        n_cmp++;
        if ({o_hwin, o_hblk, o_vwin, o_meas_vld, o_fm_cnt, o_err_hwin, o_err_hblk, o_err_vwin, o_err_seq} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got hwin=%0d hblk=%0d vwin=%0d vld=%b fm=%0d errs=%b%b%b%b want all 0",
                     o_hwin, o_hblk, o_vwin, o_meas_vld, o_fm_cnt, o_err_hwin, o_err_hblk, o_err_vwin, o_err_seq);
        end
        prst = 1'b0;
        cyc();
    endtask

    task automatic test_clean;
        frame_open();
        lines(VW);
        push_exp(HW, HBX, VW);
        frame_close();
        n_cmp++;
        if (o_meas_vld !== 1'b1 || sb.size() == 0) begin
            n_bad++; $display("FAIL clean_meas_vld: got %b want 1", o_meas_vld);
        end else begin
            e = sb.pop_front();
            n_cmp++;
            if ({o_hwin, o_hblk, o_vwin, o_fm_cnt} !== e) begin
                n_bad++; $display("FAIL clean_meas: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                                  o_hwin, o_hblk, o_vwin, o_fm_cnt, e.hwin, e.hblk, e.vwin, e.fm);
            end
        end
        n_cmp++;
        if ({o_err_hwin, o_err_hblk, o_err_vwin, o_err_seq} !== 4'b0) begin
            n_bad++; $display("FAIL clean_errs: got %b%b%b%b want 0000", o_err_hwin, o_err_hblk, o_err_vwin, o_err_seq);
        end
        cyc();
        n_cmp++;
        if (o_meas_vld !== 1'b0) begin
            n_bad++; $display("FAIL clean_vld_width: got %b want 0", o_meas_vld);
        end
    endtask

    task automatic test_hwin;
        frame_open();
        for (int i = 0; i < VW; i++) begin
            if (i == 5) begin
                href = 1'b1;
                repeat (HW - 1) cyc();
                href = 1'b0;
                n_cmp++;
                if (o_err_hwin !== 1'b0) begin
                    n_bad++; $display("FAIL hwin_early: got %b want 0", o_err_hwin);
                end
                cyc();
                n_cmp++;
                if (o_err_hwin !== 1'b1) begin
                    n_bad++; $display("FAIL hwin_flag: got %b want 1", o_err_hwin);
                end
                repeat (HB - 1) cyc();
            end else begin
                send_line(HW, HB);
            end
        end
        push_exp(HW, HBX, VW);
        frame_close();
        n_cmp++;
        if (o_meas_vld !== 1'b1 || sb.size() == 0) begin
            n_bad++; $display("FAIL hwin_meas_vld: got %b want 1", o_meas_vld);
        end else begin
            e = sb.pop_front();
            n_cmp++;
            if ({o_hwin, o_hblk, o_vwin, o_fm_cnt} !== e) begin
                n_bad++; $display("FAIL hwin_meas: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                                  o_hwin, o_hblk, o_vwin, o_fm_cnt, e.hwin, e.hblk, e.vwin, e.fm);
            end
        end
        n_cmp++;
        if ({o_err_hwin, o_err_hblk, o_err_vwin, o_err_seq} !== 4'b1000) begin
            n_bad++; $display("FAIL hwin_errs: got %b%b%b%b want 1000", o_err_hwin, o_err_hblk, o_err_vwin, o_err_seq);
        end
        err_clear();
    endtask

    task automatic test_vwin;
        frame_open();
        lines(VW - 1);
        push_exp(HW, HBX, VW - 1);
        frame_close();
        n_cmp++;
        if (o_meas_vld !== 1'b1 || sb.size() == 0) begin
            n_bad++; $display("FAIL vwin_meas_vld: got %b want 1", o_meas_vld);
        end else begin
            e = sb.pop_front();
            n_cmp++;
            if ({o_hwin, o_hblk, o_vwin, o_fm_cnt} !== e) begin
                n_bad++; $display("FAIL vwin_meas: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                                  o_hwin, o_hblk, o_vwin, o_fm_cnt, e.hwin, e.hblk, e.vwin, e.fm);
            end
        end
        n_cmp++;
        if (o_err_vwin !== 1'b1) begin
            n_bad++; $display("FAIL vwin_flag: got %b want 1", o_err_vwin);
        end
        err_clear();
        n_cmp++;
        if (o_err_vwin !== 1'b0) begin
            n_bad++; $display("FAIL vwin_clear: got %b want 0", o_err_vwin);
        end
    endtask

    task automatic test_seq;
        frame_open();
        lines(3);
        fstr = 1'b1;
        cyc();
        fstr = 1'b0;
        n_cmp++;
        if (o_err_seq !== 1'b1) begin
            n_bad++; $display("FAIL seq_restart: got %b want 1", o_err_seq);
        end
        lines(VW);
        push_exp(HW, HBX, VW);
        frame_close();
        n_cmp++;
        if (o_meas_vld !== 1'b1 || sb.size() == 0) begin
            n_bad++; $display("FAIL seq_meas_vld: got %b want 1", o_meas_vld);
        end else begin
            e = sb.pop_front();
            n_cmp++;
            if ({o_hwin, o_hblk, o_vwin, o_fm_cnt} !== e) begin
                n_bad++; $display("FAIL seq_meas: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                                  o_hwin, o_hblk, o_vwin, o_fm_cnt, e.hwin, e.hblk, e.vwin, e.fm);
            end
        end
        cyc();
        // clear collides with a fresh error (href while idle): error wins
        clr  = 1'b1;
        href = 1'b1;
        cyc();
        href = 1'b0;
        n_cmp++;
        if (o_err_seq !== 1'b1) begin
            n_bad++; $display("FAIL seq_clr_collide: got %b want 1", o_err_seq);
        end
        cyc();
        clr = 1'b0;
        n_cmp++;
        if (o_err_seq !== 1'b0) begin
            n_bad++; $display("FAIL seq_clear: got %b want 0", o_err_seq);
        end
    endtask

    task automatic test_hblk;
        frame_open();
        for (int i = 0; i < 5; i++) send_line(HW, (i == 4) ? HB + 10 : HB);
        href = 1'b1;
        n_cmp++;
        if (o_err_hblk !== 1'b0) begin
            n_bad++; $display("FAIL hblk_early: got %b want 0", o_err_hblk);
        end
        cyc();
        n_cmp++;
        if (o_err_hblk !== HBLK_ON) begin
            n_bad++; $display("FAIL hblk_flag: got %b want %b", o_err_hblk, HBLK_ON);
        end
        repeat (HW - 1) cyc();
        href = 1'b0;
        repeat (HB) cyc();
        lines(VW - 6);
        push_exp(HW, HBX, VW);
        frame_close();
        n_cmp++;
        if (o_meas_vld !== 1'b1 || sb.size() == 0) begin
            n_bad++; $display("FAIL hblk_meas_vld: got %b want 1", o_meas_vld);
        end else begin
            e = sb.pop_front();
            n_cmp++;
            if ({o_hwin, o_hblk, o_vwin, o_fm_cnt} !== e) begin
                n_bad++; $display("FAIL hblk_meas: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                                  o_hwin, o_hblk, o_vwin, o_fm_cnt, e.hwin, e.hblk, e.vwin, e.fm);
            end
        end
        n_cmp++;
        if ({o_err_hwin, o_err_hblk, o_err_vwin, o_err_seq} !== {1'b0, HBLK_ON, 2'b00}) begin
            n_bad++; $display("FAIL hblk_errs: got %b%b%b%b want 0%b00", o_err_hwin, o_err_hblk, o_err_vwin, o_err_seq, HBLK_ON);
        end
        err_clear();
    endtask

    task automatic test_saturate;
        frame_open();
        lines(VW - 1);
        send_line(70, HB);
        push_exp((1 << CW) - 1, HBX, VW);
        frame_close();
        n_cmp++;
        if (o_meas_vld !== 1'b1 || sb.size() == 0) begin
            n_bad++; $display("FAIL sat_meas_vld: got %b want 1", o_meas_vld);
        end else begin
            e = sb.pop_front();
            n_cmp++;
            if ({o_hwin, o_hblk, o_vwin, o_fm_cnt} !== e) begin
                n_bad++; $display("FAIL sat_meas: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                                  o_hwin, o_hblk, o_vwin, o_fm_cnt, e.hwin, e.hblk, e.vwin, e.fm);
            end
        end
        n_cmp++;
        if (o_err_hwin !== 1'b1) begin
            n_bad++; $display("FAIL sat_flag: got %b want 1", o_err_hwin);
        end
        err_clear();
    endtask

    task automatic test_reset_mid;
        frame_open();
        lines(3);
        href = 1'b1;
        repeat (5) cyc();
        prst = 1'b1;
        href = 1'b0;
        vref = 1'b0;
        cyc();
        prst   = 1'b0;
        fm_exp = 0;
        n_cmp++;
        if ({o_hwin, o_hblk, o_vwin, o_meas_vld, o_fm_cnt, o_err_hwin, o_err_hblk, o_err_vwin, o_err_seq} !== '0) begin
            n_bad++;
            $display("FAIL rstmid_outputs: got hwin=%0d hblk=%0d vwin=%0d vld=%b fm=%0d errs=%b%b%b%b want all 0",
                     o_hwin, o_hblk, o_vwin, o_meas_vld, o_fm_cnt, o_err_hwin, o_err_hblk, o_err_vwin, o_err_seq);
        end
        vref = 1'b1;
        send_line(HW, HB);
        frame_close();
        n_cmp++;
        if ({o_meas_vld, o_vwin, o_err_seq} !== {1'b0, CW'(0), 1'b1}) begin
            n_bad++; $display("FAIL rstmid_nofstr: got vld=%b vwin=%0d seq=%b want 0/0/1", o_meas_vld, o_vwin, o_err_seq);
        end
        err_clear();
    endtask

    task automatic test_back_to_back;
        for (int f = 0; f < 3; f++) begin
            frame_open();
            lines(VW);
            push_exp(HW, HBX, VW);
            frame_close();
            n_cmp++;
            if (o_meas_vld !== 1'b1 || sb.size() == 0) begin
                n_bad++; $display("FAIL b2b_meas_vld[%0d]: got %b want 1", f, o_meas_vld);
            end else begin
                e = sb.pop_front();
                n_cmp++;
                if ({o_hwin, o_hblk, o_vwin, o_fm_cnt} !== e) begin
                    n_bad++; $display("FAIL b2b_meas[%0d]: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                                      f, o_hwin, o_hblk, o_vwin, o_fm_cnt, e.hwin, e.hblk, e.vwin, e.fm);
                end
            end
        end
    endtask

    task automatic test_disable;
        frame_open();
        lines(2);
        en = 1'b0;
        cyc();
        en     = 1'b1;
        fm_exp = 0;
        n_cmp++;
        if ({o_fm_cnt, o_meas_vld, o_hwin, o_vwin} !== {8'd0, 1'b0, CW'(HW), CW'(VW)}) begin
            n_bad++; $display("FAIL dis_state: got fm=%0d vld=%b hwin=%0d vwin=%0d want 0/0/%0d/%0d",
                              o_fm_cnt, o_meas_vld, o_hwin, o_vwin, HW, VW);
        end
        lines(2);
        frame_close();
        n_cmp++;
        if ({o_meas_vld, o_fm_cnt, o_err_seq} !== {1'b0, 8'd0, 1'b1}) begin
            n_bad++; $display("FAIL dis_abort: got vld=%b fm=%0d seq=%b want 0/0/1", o_meas_vld, o_fm_cnt, o_err_seq);
        end
        err_clear();
    endtask

    initial begin
        prst = 1'b1; en = 1'b1; fstr = 1'b0; fend = 1'b0;
        vref = 1'b0; href = 1'b0; clr = 1'b0;
        n_cmp = 0; n_bad = 0; fm_exp = 0;
        test_reset();
        test_clean();
        test_hwin();
        test_vwin();
        test_seq();
        test_hblk();
        test_saturate();
        test_reset_mid();
        test_back_to_back();
        test_disable();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
